// File: rtl/lt24_pic_blitter.sv
// Picture RAM to LT24 LCD streamer: window-setup header
// followed by a memory-write burst over the 8080-style bus.
module lt24_pic_blitter #(
  parameter int WR_LOW  = 2,
  parameter int WR_HIGH = 2,
  parameter int MAX_PIX = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] x_start,
  input  logic [15:0] x_end,
  input  logic [15:0] y_start,
  input  logic [15:0] y_end,
  input  logic [12:0] pix_count,
  output logic        busy,
  output logic        done,
  output logic [11:0] mem_address,
  output logic        mem_chipselect,
  output logic        mem_clken,
  output logic        mem_write,
  output logic [1:0]  mem_byteenable,
  input  logic [15:0] mem_readdata,
  output logic        lcd_cs,
  output logic        lcd_rs,
  output logic        lcd_rd,
  output logic        lcd_wr,
  output logic [15:0] lcd_data
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    WR_LO,
    WR_HI,
    MEM_ADDR,
    MEM_CAP,
    FINISH
  } state_t;

  localparam logic [7:0]  LO_LAST  = 8'(WR_LOW - 1);
  localparam logic [7:0]  HI_LAST  = 8'(WR_HIGH - 1);
  localparam logic [12:0] PIX_MAX  = 13'(MAX_PIX);
  localparam logic [3:0]  HDR_LAST = 4'd10;

  state_t      state, state_n;
  logic [7:0]  cnt, cnt_n;
  logic [3:0]  hdr_idx, hdr_n;
  logic [12:0] pix_idx, pix_n;
  logic [12:0] n_q;
  logic [15:0] xs_q, xe_q, ys_q, ye_q;
  logic [15:0] data_q;
  logic        rs_q;
  logic        ld_win, ld_hdr, ld_pix;
  logic        hw_rs;
  logic [15:0] hw_data;

  // Header word selected by the index about to be presented
  always_comb begin
    hw_rs   = 1'b1;
    hw_data = 16'h0000;
    case (hdr_n)
      4'd0: begin
        hw_rs   = 1'b0;
        hw_data = 16'h002A;
      end
      4'd1: hw_data = {8'h00, xs_q[15:8]};
      4'd2: hw_data = {8'h00, xs_q[7:0]};
      4'd3: hw_data = {8'h00, xe_q[15:8]};
      4'd4: hw_data = {8'h00, xe_q[7:0]};
      4'd5: begin
        hw_rs   = 1'b0;
        hw_data = 16'h002B;
      end
      4'd6: hw_data = {8'h00, ys_q[15:8]};
      4'd7: hw_data = {8'h00, ys_q[7:0]};
      4'd8: hw_data = {8'h00, ye_q[15:8]};
      4'd9: hw_data = {8'h00, ye_q[7:0]};
      4'd10: begin
        hw_rs   = 1'b0;
        hw_data = 16'h002C;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    hdr_n   = hdr_idx;
    pix_n   = pix_idx;
    ld_win  = 1'b0;
    ld_hdr  = 1'b0;
    ld_pix  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = SETUP;
          ld_win  = 1'b1;
          ld_hdr  = 1'b1;
          hdr_n   = 4'd0;
          pix_n   = 13'd0;
        end
      end
      SETUP: begin
        state_n = WR_LO;
        cnt_n   = 8'd0;
      end
      WR_LO: begin
        if (cnt == LO_LAST) begin
          state_n = WR_HI;
          cnt_n   = 8'd0;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      WR_HI: begin
        if (cnt == HI_LAST) begin
          cnt_n = 8'd0;
          if (hdr_idx != HDR_LAST) begin
            state_n = SETUP;
            hdr_n   = hdr_idx + 4'd1;
            ld_hdr  = 1'b1;
          end else if (pix_idx < n_q) begin
            state_n = MEM_ADDR;
          end else begin
            state_n = FINISH;
          end
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      MEM_ADDR: state_n = MEM_CAP;
      MEM_CAP: begin
        state_n = WR_LO;
        cnt_n   = 8'd0;
        ld_pix  = 1'b1;
        pix_n   = pix_idx + 13'd1;
      end
      FINISH: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= 8'd0;
      hdr_idx <= 4'd0;
      pix_idx <= 13'd0;
      n_q     <= 13'd0;
      xs_q    <= 16'h0000;
      xe_q    <= 16'h0000;
      ys_q    <= 16'h0000;
      ye_q    <= 16'h0000;
      data_q  <= 16'h0000;
      rs_q    <= 1'b1;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      hdr_idx <= hdr_n;
      pix_idx <= pix_n;
      if (ld_win) begin
        xs_q <= x_start;
        xe_q <= x_end;
        ys_q <= y_start;
        ye_q <= y_end;
        n_q  <= (pix_count > PIX_MAX) ? PIX_MAX : pix_count;
      end
      if (ld_hdr) begin
        rs_q   <= hw_rs;
        data_q <= hw_data;
      end else if (ld_pix) begin
        rs_q   <= 1'b1;
        data_q <= mem_readdata;
      end
    end
  end

  // cs is released only while idle and in the completion cycle
  assign lcd_cs         = (state == IDLE) || (state == FINISH);
  assign lcd_wr         = (state != WR_LO);
  assign lcd_rd         = 1'b1;
  assign lcd_rs         = rs_q;
  assign lcd_data       = data_q;
  assign busy           = (state != IDLE);
  assign done           = (state == FINISH);
  assign mem_chipselect = (state == MEM_ADDR);
  assign mem_address    = pix_idx[11:0];
  assign mem_clken      = 1'b1;
  assign mem_write      = 1'b0;
  assign mem_byteenable = 2'b11;

endmodule

// File: doc/lt24_pic_blitter.md
Name: lt24_pic_blitter

Overview:
- Hardware reader for the picture dual-port RAM: the SOPC side fills the RAM, and this block reads it back through the RAM's second port.
- Streams the contents to the LT24 LCD over its 8080-style bus (cs/rs/rd/wr/data): window-setup commands first, then a memory-write burst of pixels.
- Sits in the top level beside the SOPC and drives the LCD bus while the SOPC's own LCD controller is idle (top-level mux, outside this block).

Parameters:
- WR_LOW, 2, cycles wr is held low per bus word (≥1).
- WR_HIGH, 2, cycles wr is held high per bus word (≥1).
- MAX_PIX, 4096, RAM depth in 16-bit words; pix_count above this is clamped.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; ignored unless idle.
- x_start  in  16  column start; latched on accepted start.
- x_end  in  16  column end; latched.
- y_start  in  16  page start; latched.
- y_end  in  16  page end; latched.
- pix_count  in  13  pixels to send; latched.
- busy  out  1  high from the cycle after an accepted start through the DONE cycle.
- done  out  1  one-cycle pulse at completion.
- mem_address  out  12  RAM word address.
- mem_chipselect  out  1  read strobe.
- mem_clken  out  1  constant 1.
- mem_write  out  1  constant 0.
- mem_byteenable  out  2  constant 2'b11.
- mem_readdata  in  16  RAM data, valid 1 cycle after address+chipselect.
- lcd_cs  out  1  active-low chip select.
- lcd_rs  out  1  0 = command, 1 = data.
- lcd_rd  out  1  constant 1.
- lcd_wr  out  1  active-low write strobe.
- lcd_data  out  16  bus data.

Behaviour:
- Reset values: lcd_cs=1, lcd_rs=1, lcd_wr=1, lcd_data=0, busy=0, done=0, mem_chipselect=0, mem_address=0; state IDLE.
- Reset asserted mid-operation returns the block to IDLE and restores the reset values on the next edge. No partial word is completed.
- Pixel count: n = min(pix_count, MAX_PIX). n=0 sends the 11 header words only.
- Word sequence (rs, value):
  - (0, 0x002A)
  - (1, x_start[15:8]), (1, x_start[7:0]), (1, x_end[15:8]), (1, x_end[7:0])
  - (0, 0x002B)
  - (1, y_start[15:8]), (1, y_start[7:0]), (1, y_end[15:8]), (1, y_end[7:0])
  - (0, 0x002C)
  - n pixel words (1, RAM[0..n-1])
  - Byte values are zero-extended to 16 bits.
- States: IDLE, SETUP, WR_LO, WR_HI, MEM_ADDR, MEM_CAP, FINISH.
- IDLE: on start, latch inputs, word index = 0, go to SETUP.
- SETUP (1 cycle): lcd_cs=0, lcd_wr=1; lcd_rs and lcd_data take the header word's values.
- MEM_CAP (1 cycle): lcd_cs=0, lcd_wr=1, lcd_rs=1, lcd_data <= mem_readdata.
- WR_LO: lcd_wr=0 for WR_LOW cycles.
- WR_HI: lcd_wr=1 for WR_HIGH cycles.
- After WR_HI, the next state is chosen as follows:
  - another header word remains → SETUP;
  - a pixel remains → MEM_ADDR;
  - otherwise → FINISH.
- MEM_ADDR (1 cycle): mem_chipselect=1, mem_address = pixel index; lcd_wr stays 1; then MEM_CAP.
- FINISH (1 cycle): lcd_cs=1, done=1; next cycle is IDLE with busy=0.
- lcd_data and lcd_rs are stable from SETUP/MEM_CAP through the end of WR_HI. lcd_cs stays low continuously from the first SETUP through the last WR_HI.
- Word period: header word = 1+WR_LOW+WR_HIGH cycles; pixel word = 2+WR_LOW+WR_HIGH cycles.
- Total busy cycles = 11·(1+WR_LOW+WR_HIGH) + n·(2+WR_LOW+WR_HIGH) + 1.
- Pixel index runs 0..n-1 (12 bits, no wrap, since n ≤ 4096). Index 4095 is a legal last pixel.
- start asserted while busy, including in the FINISH cycle, is ignored. A start in the cycle after done is accepted.
- Latched window/count values are unaffected by input changes while busy.

Test Plan:
- Reset then idle 10 cycles → lcd_cs=1, lcd_wr=1, lcd_rd=1, busy=0, mem_chipselect=0 throughout.
- start, x=0..239, y=0..319, pix_count=4, RAM[0..3]=0xF800,0x07E0,0x001F,0xFFFF, defaults:
  - captured words are 2A,00,00,00,EF,2B,00,00,01,3F,2C,F800,07E0,001F,FFFF;
  - rs=0 exactly on the three command words;
  - busy for 55+24+1=80 cycles, one done pulse.
- pix_count=0 → 11 header words only, done after 56 busy cycles, mem_chipselect never asserted.
- pix_count=5000 → exactly 4096 pixel writes, last mem_address=4095, no wrap to 0.
- start pulsed mid-burst, and again in the FINISH cycle → ignored, word count unchanged; start the cycle after done → new sequence begins.
- reset asserted during a pixel WR_LO → next cycle lcd_cs=1, lcd_wr=1, busy=0; a subsequent start produces a complete, correct sequence.
